// File: rtl/mac_tile_recfg.sv
// Registered reconfigurable MAC tile: full-width or 2-lane SIMD weight-stationary PE.
// Optional MAC_SAT_EN: saturating final add plus a sat_hit pulse alongside valid_s.
module mac_tile_recfg #(
   parameter int bw      = 4,
   parameter int psum_bw = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [bw-1:0]      in_w,
   output logic [bw-1:0]      out_e,
   input  logic [1:0]         inst_w,
   output logic [1:0]         inst_e,
   input  logic [psum_bw-1:0] in_n,
   output logic [psum_bw-1:0] out_s,
   output logic               valid_s,
   input  logic               mode,
   input  logic               wclr,
   output logic               mode_q,
   output logic               exec_err,
   output logic [1:0]         state_dbg
`ifdef MAC_SAT_EN
   ,output logic              sat_hit
`endif
);

   // Handshake: there is no backpressure. inst_w[0] qualifies in_w as a weight,
   // inst_w[1] qualifies in_w/in_n as an execute; valid_s marks a fresh out_s.
   typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

   state_t                state;
   logic [bw-1:0]         a_q;
   logic [bw-1:0]         w0;
   logic [bw-1:0]         w1;
   logic [psum_bw-1:0]    c_q;
   logic [1:0]            inst_q;

   logic signed [psum_bw-1:0] a_full, a_lo, a_hi, w0_x, w1_x, c_x;
   logic signed [psum_bw-1:0] prod;
   logic signed [psum_bw-1:0] result;
`ifdef MAC_SAT_EN
   logic signed [psum_bw:0]   sum_x;
   logic                      sat_flag;
`endif

   // Activations are zero-extended, weights sign-extended; psum_bw holds any product exactly.
   assign a_full = {{(psum_bw-bw){1'b0}}, a_q};
   assign a_lo   = {{(psum_bw-bw/2){1'b0}}, a_q[bw/2-1:0]};
   assign a_hi   = {{(psum_bw-bw/2){1'b0}}, a_q[bw-1:bw/2]};
   assign w0_x   = {{(psum_bw-bw){w0[bw-1]}}, w0};
   assign w1_x   = {{(psum_bw-bw){w1[bw-1]}}, w1};
   assign c_x    = c_q;

   always_comb begin
      prod = mode_q ? (a_lo * w0_x + a_hi * w1_x) : (a_full * w0_x);
      result = prod + c_x;
`ifdef MAC_SAT_EN
      sat_flag = 1'b0;
      sum_x = {prod[psum_bw-1], prod} + {c_x[psum_bw-1], c_x};
      if (sum_x[psum_bw] != sum_x[psum_bw-1]) begin
         sat_flag = 1'b1;
         result = sum_x[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= EMPTY;
         a_q      <= '0;
         w0       <= '0;
         w1       <= '0;
         c_q      <= '0;
         inst_q   <= '0;
         out_s    <= '0;
         valid_s  <= 1'b0;
         mode_q   <= 1'b0;
         exec_err <= 1'b0;
`ifdef MAC_SAT_EN
         sat_hit  <= 1'b0;
`endif
      end else begin
         // Loads consumed by this tile must not be seen by the east neighbour.
         inst_q[1] <= inst_w[1];
         inst_q[0] <= (state == FULL && !wclr) ? inst_w[0] : 1'b0;
         if (inst_w != 2'b00) a_q <= in_w;
         if (inst_w[1]) c_q <= in_n;

         valid_s <= inst_q[1];
`ifdef MAC_SAT_EN
         sat_hit <= 1'b0;
`endif
         if (inst_q[1]) begin
            if (state == FULL) begin
               out_s <= result;
`ifdef MAC_SAT_EN
               sat_hit <= sat_flag;
`endif
            end else begin
               out_s    <= c_q;
               exec_err <= 1'b1;
            end
         end

         if (wclr) begin
            state <= EMPTY;
         end else begin
            case (state)
               EMPTY: if (inst_w[0]) begin
                  w0     <= in_w;
                  mode_q <= mode;
                  state  <= mode ? HALF : FULL;
               end
               HALF: if (inst_w[0]) begin
                  w1    <= in_w;
                  state <= FULL;
               end
               default: state <= FULL;
            endcase
         end
      end
   end

   assign out_e     = a_q;
   assign inst_e    = inst_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_mac_tile_recfg.sv
// Directed table-driven bench for mac_tile_recfg (bw=4, psum_bw=16), plus async-reset sequence.
module tb_mac_tile_recfg;

   logic        clk;
   logic        reset;
   logic [3:0]  in_w;
   logic [3:0]  out_e;
   logic [1:0]  inst_w;
   logic [1:0]  inst_e;
   logic [15:0] in_n;
   logic [15:0] out_s;
   logic        valid_s;
   logic        mode;
   logic        wclr;
   logic        mode_q;
   logic        exec_err;
   logic [1:0]  state_dbg;
`ifdef MAC_SAT_EN
   logic        sat_hit;
   localparam logic [15:0] OVF_RES = 16'h7FFF;
   localparam logic        OVF_SAT = 1'b1;
`else
   localparam logic [15:0] OVF_RES = 16'h8059;
   localparam logic        OVF_SAT = 1'b0;
`endif

   mac_tile_recfg #(.bw(4), .psum_bw(16)) dut (
      .clk(clk), .reset(reset), .in_w(in_w), .out_e(out_e), .inst_w(inst_w), .inst_e(inst_e),
      .in_n(in_n), .out_s(out_s), .valid_s(valid_s), .mode(mode), .wclr(wclr),
      .mode_q(mode_q), .exec_err(exec_err), .state_dbg(state_dbg)
`ifdef MAC_SAT_EN
      , .sat_hit(sat_hit)
`endif
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  inst;
      logic [3:0]  iw;
      logic [15:0] in;
      logic        md;
      logic        clr;
      logic [3:0]  e_out_e;
      logic [1:0]  e_inst_e;
      logic [15:0] e_out_s;
      logic        e_valid;
      logic        e_mode_q;
      logic        e_err;
      logic [1:0]  e_state;
      logic        e_sat;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   row = -1;

   task automatic add(input logic rst, input logic [1:0] inst, input logic [3:0] iw,
                      input logic [15:0] in, input logic md, input logic clr,
                      input logic [3:0] eoe, input logic [1:0] eie, input logic [15:0] eos,
                      input logic ev, input logic emq, input logic eer, input logic [1:0] est,
                      input logic esat);
      vec_t v;
      v.rst = rst; v.inst = inst; v.iw = iw; v.in = in; v.md = md; v.clr = clr;
      v.e_out_e = eoe; v.e_inst_e = eie; v.e_out_s = eos; v.e_valid = ev;
      v.e_mode_q = emq; v.e_err = eer; v.e_state = est; v.e_sat = esat;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   // Called in the low clock phase; reset releases before the next rising edge.
   task automatic pulse_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic drive(input logic [1:0] inst, input logic [3:0] iw, input logic [15:0] in,
                        input logic md, input logic clr);
      inst_w = inst; in_w = iw; in_n = in; mode = md; wclr = clr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all(input vec_t v);
      check("out_e",    16'(out_e),     16'(v.e_out_e));
      check("inst_e",   16'(inst_e),    16'(v.e_inst_e));
      check("out_s",    out_s,          v.e_out_s);
      check("valid_s",  16'(valid_s),   16'(v.e_valid));
      check("mode_q",   16'(mode_q),    16'(v.e_mode_q));
      check("exec_err", 16'(exec_err),  16'(v.e_err));
      check("state",    16'(state_dbg), 16'(v.e_state));
`ifdef MAC_SAT_EN
      check("sat_hit",  16'(sat_hit),   16'(v.e_sat));
`endif
   endtask

   initial begin
      reset = 1'b0; in_w = '0; inst_w = '0; in_n = '0; mode = 1'b0; wclr = 1'b0;

      // rst inst  in_w   in_n      md clr | out_e inst_e out_s  v mq err st sat
      // full-width: w0=-3, a=7, psum 100 -> 79
      add(1, 2'b01, 4'hD, 16'd0,    0, 0,  4'hD, 2'b00, 16'd0,  0, 0, 0, 2, 0);
      add(0, 2'b10, 4'h7, 16'd100,  0, 0,  4'h7, 2'b10, 16'd0,  0, 0, 0, 2, 0);
      add(0, 2'b00, 4'h0, 16'd0,    0, 0,  4'h7, 2'b00, 16'd79, 1, 0, 0, 2, 0);
      add(0, 2'b00, 4'h0, 16'd0,    0, 0,  4'h7, 2'b00, 16'd79, 0, 0, 0, 2, 0);
      // SIMD w0=5, w1=-2; mode change during second load ignored; back-to-back executes
      add(1, 2'b01, 4'h5, 16'd0,    1, 0,  4'h5, 2'b00, 16'd0,  0, 1, 0, 1, 0);
      add(0, 2'b01, 4'hE, 16'd0,    0, 0,  4'hE, 2'b00, 16'd0,  0, 1, 0, 2, 0);
      add(0, 2'b10, 4'hE, 16'd10,   0, 0,  4'hE, 2'b10, 16'd0,  0, 1, 0, 2, 0);
      add(0, 2'b10, 4'hF, 16'd20,   0, 0,  4'hF, 2'b10, 16'd14, 1, 1, 0, 2, 0);
      add(0, 2'b00, 4'h0, 16'd0,    0, 0,  4'hF, 2'b00, 16'd29, 1, 1, 0, 2, 0);
      add(0, 2'b00, 4'h0, 16'd0,    0, 0,  4'hF, 2'b00, 16'd29, 0, 1, 0, 2, 0);
      // load gating: third load forwarded east, weights unchanged (a=1 -> 1*5)
      add(1, 2'b01, 4'h5, 16'd0,    1, 0,  4'h5, 2'b00, 16'd0,  0, 1, 0, 1, 0);
      add(0, 2'b01, 4'hE, 16'd0,    1, 0,  4'hE, 2'b00, 16'd0,  0, 1, 0, 2, 0);
      add(0, 2'b01, 4'h4, 16'd0,    1, 0,  4'h4, 2'b01, 16'd0,  0, 1, 0, 2, 0);
      add(0, 2'b00, 4'h0, 16'd0,    1, 0,  4'h4, 2'b00, 16'd0,  0, 1, 0, 2, 0);
      add(0, 2'b10, 4'h1, 16'd0,    1, 0,  4'h1, 2'b10, 16'd0,  0, 1, 0, 2, 0);
      add(0, 2'b00, 4'h0, 16'd0,    1, 0,  4'h1, 2'b00, 16'd5,  1, 1, 0, 2, 0);
      // overflow: 7*15 + 0x7FF0
      add(1, 2'b01, 4'h7, 16'd0,    0, 0,  4'h7, 2'b00, 16'd0,  0, 0, 0, 2, 0);
      add(0, 2'b10, 4'hF, 16'h7FF0, 0, 0,  4'hF, 2'b10, 16'd0,  0, 0, 0, 2, 0);
      add(0, 2'b00, 4'h0, 16'd0,    0, 0,  4'hF, 2'b00, OVF_RES, 1, 0, 0, 2, OVF_SAT);
      add(0, 2'b00, 4'h0, 16'd0,    0, 0,  4'hF, 2'b00, OVF_RES, 0, 0, 0, 2, 0);
      // clear beats a load, then execute while EMPTY -> pass-through and sticky error
      add(1, 2'b01, 4'h5, 16'd0,    1, 0,  4'h5, 2'b00, 16'd0,  0, 1, 0, 1, 0);
      add(0, 2'b01, 4'hE, 16'd0,    1, 1,  4'hE, 2'b00, 16'd0,  0, 1, 0, 0, 0);
      add(0, 2'b10, 4'h0, 16'd55,   1, 0,  4'h0, 2'b10, 16'd0,  0, 1, 0, 0, 0);
      add(0, 2'b00, 4'h0, 16'd0,    1, 0,  4'h0, 2'b00, 16'd55, 1, 1, 1, 0, 0);
      add(0, 2'b00, 4'h0, 16'd0,    1, 0,  4'h0, 2'b00, 16'd55, 0, 1, 1, 0, 0);
      add(0, 2'b01, 4'h2, 16'd0,    0, 0,  4'h2, 2'b00, 16'd55, 0, 0, 1, 2, 0);
      add(0, 2'b10, 4'h3, 16'd1,    0, 0,  4'h3, 2'b10, 16'd55, 0, 0, 1, 2, 0);
      add(0, 2'b00, 4'h0, 16'd0,    0, 0,  4'h3, 2'b00, 16'd7,  1, 0, 1, 2, 0);

      // reset state
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_out_s",   out_s, 16'd0);
      check("rst_out_e",   16'(out_e), 16'd0);
      check("rst_inst_e",  16'(inst_e), 16'd0);
      check("rst_valid",   16'(valid_s), 16'd0);
      check("rst_err",     16'(exec_err), 16'd0);
      check("rst_state",   16'(state_dbg), 16'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         row = i;
         if (vecs[i].rst) pulse_reset();
         drive(vecs[i].inst, vecs[i].iw, vecs[i].in, vecs[i].md, vecs[i].clr);
         check_all(vecs[i]);
      end

      // async reset mid-execute: outputs clear without a clock edge
      row = 1000;
      pulse_reset();
      drive(2'b10, 4'h9, 16'd123, 0, 0);
      drive(2'b10, 4'h6, 16'd5, 0, 0);
      check("pre_out_s", out_s, 16'd123);
      check("pre_err",   16'(exec_err), 16'd1);
      check("pre_inst_e", 16'(inst_e), 16'd2);
      #1;
      reset = 1'b0;
      #1;
      check("async_out_s",  out_s, 16'd0);
      check("async_out_e",  16'(out_e), 16'd0);
      check("async_inst_e", 16'(inst_e), 16'd0);
      check("async_valid",  16'(valid_s), 16'd0);
      check("async_err",    16'(exec_err), 16'd0);
      check("async_mode_q", 16'(mode_q), 16'd0);
      #1;
      reset = 1'b1;
      drive(2'b00, 4'h0, 16'd0, 0, 0);
      check("post_valid", 16'(valid_s), 16'd0);
      check("post_out_s", out_s, 16'd0);
      check("post_state", 16'(state_dbg), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
